// File: rtl/icache_linefill_collector.sv
// Collects interleaved downstream refill beats into per-txnid line buffers and
// hands completed lines out in completion order over a valid/ready handshake.
//
// state   | meaning
// FREE    | buffer unused, may be allocated by a beat with an unknown txnid
// COLLECT | buffer owns a txnid and is gathering beats
// FULL    | all beats present, index queued in the completion fifo
module icache_linefill_collector #(
  parameter int DS_DATA_WIDTH = 128,
  parameter int LINE_WIDTH    = 512,
  parameter int BEATS         = LINE_WIDTH / DS_DATA_WIDTH,
  parameter int TXNID_WIDTH   = 5,
  parameter int OPCODE_WIDTH  = 4,
  parameter int N_BUF         = 2,
  parameter logic [OPCODE_WIDTH-1:0] OP_DATA_ERR = OPCODE_WIDTH'(2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     downstream_rxdat_vld,
  output logic                     downstream_rxdat_rdy,
  input  logic [OPCODE_WIDTH-1:0]  downstream_rxdat_opcode,
  input  logic [TXNID_WIDTH-1:0]   downstream_rxdat_txnid,
  input  logic [DS_DATA_WIDTH-1:0] downstream_rxdat_data,
  output logic                     linefill_vld,
  input  logic                     linefill_rdy,
  output logic [TXNID_WIDTH-1:0]   linefill_txnid,
  output logic [LINE_WIDTH-1:0]    linefill_data,
  output logic                     linefill_err,
  output logic                     busy
);

  localparam int CNT_W  = $clog2(BEATS);
  localparam int IDX_W  = (N_BUF > 1) ? $clog2(N_BUF) : 1;
  localparam int FCNT_W = $clog2(N_BUF + 1);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } buf_state_e;

  buf_state_e             state_q [N_BUF];
  buf_state_e             state_d [N_BUF];
  logic [TXNID_WIDTH-1:0] txnid_q [N_BUF];
  logic [TXNID_WIDTH-1:0] txnid_d [N_BUF];
  logic [CNT_W-1:0]       cnt_q   [N_BUF];
  logic [CNT_W-1:0]       cnt_d   [N_BUF];
  logic                   err_q   [N_BUF];
  logic                   err_d   [N_BUF];
  logic [LINE_WIDTH-1:0]  data_q  [N_BUF];
  logic [LINE_WIDTH-1:0]  data_d  [N_BUF];

  logic [IDX_W-1:0]  fifo_q [N_BUF];
  logic [IDX_W-1:0]  fifo_d [N_BUF];
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic             match_hit, free_hit;
  logic [IDX_W-1:0] match_idx, free_idx, tgt_idx, head_idx;
  logic [CNT_W-1:0] tgt_cnt;
  logic             accept, last_beat, beat_err, push, pop;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(N_BUF - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Lookup: FULL buffers are deliberately excluded so a reused txnid starts a new line.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < N_BUF; i++) begin
      if (!match_hit && state_q[i] == ST_COLLECT && txnid_q[i] == downstream_rxdat_txnid) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!free_hit && state_q[i] == ST_FREE) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign downstream_rxdat_rdy = !rst && (match_hit || free_hit);
  assign accept    = downstream_rxdat_vld && downstream_rxdat_rdy;
  assign tgt_idx   = match_hit ? match_idx : free_idx;
  assign tgt_cnt   = match_hit ? cnt_q[match_idx] : '0;
  assign last_beat = (tgt_cnt == CNT_W'(BEATS - 1));
  assign beat_err  = (downstream_rxdat_opcode == OP_DATA_ERR);
  assign push      = accept && last_beat;

  assign linefill_vld = (fcnt_q != '0);
  assign pop          = linefill_vld && linefill_rdy;
  assign head_idx     = fifo_q[rd_ptr_q];

  assign linefill_txnid = linefill_vld ? txnid_q[head_idx] : '0;
  assign linefill_data  = linefill_vld ? data_q[head_idx]  : '0;
  assign linefill_err   = linefill_vld ? err_q[head_idx]   : 1'b0;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_BUF; i++) begin
      if (state_q[i] != ST_FREE) busy = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    txnid_d  = txnid_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    data_d   = data_q;
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fcnt_d   = fcnt_q;

    // The popped buffer is FULL and the beat target is FREE/COLLECT, so they never collide.
    if (pop) begin
      state_d[head_idx] = ST_FREE;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end

    if (accept) begin
      for (int s = 0; s < BEATS; s++) begin
        if (tgt_cnt == CNT_W'(s)) begin
          data_d[tgt_idx][s*DS_DATA_WIDTH +: DS_DATA_WIDTH] = downstream_rxdat_data;
        end
      end
      err_d[tgt_idx] = match_hit ? (err_q[tgt_idx] | beat_err) : beat_err;
      if (!match_hit) txnid_d[tgt_idx] = downstream_rxdat_txnid;
      if (last_beat) begin
        state_d[tgt_idx] = ST_FULL;
        cnt_d[tgt_idx]   = '0;
        fifo_d[wr_ptr_q] = tgt_idx;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end else begin
        state_d[tgt_idx] = ST_COLLECT;
        cnt_d[tgt_idx]   = tgt_cnt + CNT_W'(1);
      end
    end

    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BUF; i++) begin
        state_q[i] <= ST_FREE;
        txnid_q[i] <= '0;
        cnt_q[i]   <= '0;
        err_q[i]   <= 1'b0;
        fifo_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      txnid_q  <= txnid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Line payload needs no reset: slots are rewritten before a buffer can reach FULL.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_icache_linefill_collector.sv
// Directed scoreboard bench for icache_linefill_collector: expected lines are
// queued as refills are issued and a monitor checks each handshaken line.
module tb_icache_linefill_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_vld = 1'b0;
  logic         rx_rdy;
  logic [3:0]   rx_op = 4'h0;
  logic [4:0]   rx_txnid = 5'd0;
  logic [127:0] rx_data = '0;
  logic         lf_vld;
  logic         lf_rdy = 1'b1;
  logic [4:0]   lf_txnid;
  logic [511:0] lf_data;
  logic         lf_err;
  logic         busy;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0]   txnid;
    logic [511:0] data;
    logic         err;
  } exp_t;
  exp_t exp_q[$];

  icache_linefill_collector dut (
    .clk                     (clk),
    .rst                     (rst),
    .downstream_rxdat_vld    (rx_vld),
    .downstream_rxdat_rdy    (rx_rdy),
    .downstream_rxdat_opcode (rx_op),
    .downstream_rxdat_txnid  (rx_txnid),
    .downstream_rxdat_data   (rx_data),
    .linefill_vld            (lf_vld),
    .linefill_rdy            (lf_rdy),
    .linefill_txnid          (lf_txnid),
    .linefill_data           (lf_data),
    .linefill_err            (lf_err),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [3:0] n);
    return {32{n}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] id, input logic [511:0] d, input logic e);
    exp_t x;
    x.txnid = id;
    x.data  = d;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Drive one beat starting just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [4:0] id, input logic [3:0] op, input logic [127:0] d);
    int  n;
    logic acc;
    rx_vld = 1'b1;
    rx_txnid = id;
    rx_op = op;
    rx_data = d;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rx_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    rx_vld = 1'b0;
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL beat_timeout: txnid %0d never accepted, expected acceptance within 200 cycles", id);
    end
  endtask

  // Full refill of beats pat(b), pat(b+1), ...; err_beat < 0 means no error beat.
  task automatic send_line(input logic [4:0] id, input logic [3:0] b, input int err_beat);
    logic [511:0] d;
    d = {pat(b + 4'd3), pat(b + 4'd2), pat(b + 4'd1), pat(b)};
    push_exp(id, d, err_beat >= 0);
    for (int k = 0; k < 4; k++) begin
      send_beat(id, (k == err_beat) ? 4'h2 : 4'h0, pat(b + 4'(k)));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && lf_vld && lf_rdy) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_line: got txnid %0d, expected no line", lf_txnid);
        end else begin
          e = exp_q.pop_front();
          chk("line_txnid", 512'(lf_txnid), 512'(e.txnid));
          chk("line_data", lf_data, e.data);
          chk("line_err", 512'(lf_err), 512'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [511:0] d_bp;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 512'(lf_vld), 512'(0));
    chk("rst_txnid", 512'(lf_txnid), 512'(0));
    chk("rst_data", lf_data, 512'(0));
    chk("rst_err", 512'(lf_err), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_rdy", 512'(rx_rdy), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // single refill, latency and busy release
    lf_rdy = 1'b1;
    send_line(5'd3, 4'h0, -1);
    @(negedge clk);
    chk("single_vld_latency", 512'(lf_vld), 512'(1));
    chk("single_busy_before_pop", 512'(busy), 512'(1));
    @(negedge clk);
    chk("single_vld_after_pop", 512'(lf_vld), 512'(0));
    chk("single_busy_after_pop", 512'(busy), 512'(0));
    idle(2);

    // interleave A=1, B=2: B completes first
    send_beat(5'd1, 4'h0, pat(4'h4));
    send_beat(5'd2, 4'h0, pat(4'h8));
    send_beat(5'd1, 4'h0, pat(4'h5));
    send_beat(5'd2, 4'h0, pat(4'h9));
    send_beat(5'd2, 4'h0, pat(4'hA));
    push_exp(5'd2, {pat(4'hB), pat(4'hA), pat(4'h9), pat(4'h8)}, 1'b0);
    send_beat(5'd2, 4'h0, pat(4'hB));
    send_beat(5'd1, 4'h0, pat(4'h6));
    push_exp(5'd1, {pat(4'h7), pat(4'h6), pat(4'h5), pat(4'h4)}, 1'b0);
    send_beat(5'd1, 4'h0, pat(4'h7));
    idle(3);
    chk("interleave_busy_idle", 512'(busy), 512'(0));

    // error merge only affects its own line
    send_line(5'd5, 4'h1, 2);
    send_line(5'd6, 4'h3, -1);
    idle(3);

    // backpressure: outputs held while rdy=0
    lf_rdy = 1'b0;
    d_bp = {pat(4'hF), pat(4'hE), pat(4'hD), pat(4'hC)};
    send_line(5'd9, 4'hC, -1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_vld_hold", 512'(lf_vld), 512'(1));
      chk("bp_txnid_hold", 512'(lf_txnid), 512'(9));
      chk("bp_data_hold", lf_data, d_bp);
      @(posedge clk);
      #1;
    end
    lf_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_single_pop", 512'(lf_vld), 512'(0));
    @(posedge clk);
    #1;

    // full stall: both buffers collecting, new txnid 7 refused
    lf_rdy = 1'b0;
    send_beat(5'd10, 4'h0, pat(4'h0));
    send_beat(5'd11, 4'h0, pat(4'h4));
    rx_vld = 1'b1;
    rx_txnid = 5'd7;
    rx_op = 4'h0;
    rx_data = pat(4'h8);
    repeat (3) begin
      @(negedge clk);
      chk("stall_rdy_collect", 512'(rx_rdy), 512'(0));
      @(posedge clk);
      #1;
    end
    rx_vld = 1'b0;
    send_beat(5'd10, 4'h0, pat(4'h1));
    send_beat(5'd10, 4'h0, pat(4'h2));
    push_exp(5'd10, {pat(4'h3), pat(4'h2), pat(4'h1), pat(4'h0)}, 1'b0);
    send_beat(5'd10, 4'h0, pat(4'h3));
    rx_vld = 1'b1;
    rx_txnid = 5'd7;
    rx_data = pat(4'h8);
    @(negedge clk);
    chk("stall_rdy_full", 512'(rx_rdy), 512'(0));
    @(posedge clk);
    #1;
    lf_rdy = 1'b1;
    @(negedge clk);
    chk("stall_rdy_pop_cycle", 512'(rx_rdy), 512'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_rdy_after_pop", 512'(rx_rdy), 512'(1));
    @(posedge clk);
    #1;
    rx_vld = 1'b0;
    send_beat(5'd11, 4'h0, pat(4'h5));
    send_beat(5'd11, 4'h0, pat(4'h6));
    push_exp(5'd11, {pat(4'h7), pat(4'h6), pat(4'h5), pat(4'h4)}, 1'b0);
    send_beat(5'd11, 4'h0, pat(4'h7));
    send_beat(5'd7, 4'h0, pat(4'h9));
    send_beat(5'd7, 4'h0, pat(4'hA));
    push_exp(5'd7, {pat(4'hB), pat(4'hA), pat(4'h9), pat(4'h8)}, 1'b0);
    send_beat(5'd7, 4'h0, pat(4'hB));
    idle(3);
    chk("stall_busy_idle", 512'(busy), 512'(0));

    // reset mid-refill discards partial line
    send_beat(5'd12, 4'h0, pat(4'hA));
    send_beat(5'd12, 4'h2, pat(4'hB));
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    chk("midrst_vld", 512'(lf_vld), 512'(0));
    chk("midrst_data", lf_data, 512'(0));
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_rdy", 512'(rx_rdy), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send_line(5'd12, 4'h4, -1);
    idle(4);

    chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
